// File: rtl/rx_char_sequencer_pkg.sv
// Shared types and constants for the ISO7816 T=0 receive sequencer.
package rx_char_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ERR_WAIT  = 2'd1,
    ERR_DRIVE = 2'd2
  } seqState_t;

  typedef logic [7:0] rxByte_t;

  // Error-signal low time expressed in half-ETUs (1.5 ETU).
  localparam int ERR_HALF_ETUS = 3;

endpackage

// File: rtl/rx_char_sequencer_if.sv
// Downstream byte stream port: valid/ready handshake carrying one received character.
interface rx_char_sequencer_if;
  import rx_char_sequencer_pkg::*;

  rxByte_t rxData;
  logic    rxValid;
  logic    rxReady;

  modport master (output rxData, output rxValid, input rxReady);
  modport slave  (input rxData, input rxValid, output rxReady);

endinterface

// File: rtl/rx_char_sequencer_etu_ticker.sv
// Free-running ETU divider: one-cycle tick every clocksPerBit clocks, realigned by restart.
module etu_ticker #(
  parameter int CLOCK_PER_BIT_WIDTH = 13
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           restart,
  input  logic [CLOCK_PER_BIT_WIDTH-1:0] clocksPerBit,
  output logic                           tick
);

  localparam logic [CLOCK_PER_BIT_WIDTH-1:0] CPB_ONE = 1;

  logic [CLOCK_PER_BIT_WIDTH-1:0] count;
  logic                           atEnd;

  // The >= compare lets a shortened clocksPerBit wrap immediately instead of overflowing.
  assign atEnd = (count >= clocksPerBit - CPB_ONE);
  assign tick  = atEnd && !restart;

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      count <= '0;
    end else if (atEnd) begin
      count <= '0;
    end else begin
      count <= count + CPB_ONE;
    end
  end

endmodule

// File: rtl/rx_char_sequencer.sv
// Sequences an RxCore for T=0 reception: byte hand-off, parity-error signalling with retries, CWT.
module rx_char_sequencer
  import rx_char_sequencer_pkg::*;
#(
  parameter int CLOCK_PER_BIT_WIDTH = 13,
  parameter int CWT_WIDTH           = 16,
  parameter int RETRY_WIDTH         = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CLOCK_PER_BIT_WIDTH-1:0] clocksPerBit,
  input  logic                           errSignalEn,
  input  logic [RETRY_WIDTH-1:0]         maxRetries,
  input  logic [CWT_WIDTH-1:0]           cwtEtus,
  input  logic                           clearErrors,
  input  rxByte_t                        coreData,
  input  logic                           coreReady,
  input  logic                           coreFrameErr,
  input  logic                           coreOverrun,
  input  logic                           coreEndOfRx,
  input  logic                           coreStopBit,
  output logic                           coreAck,
  output logic                           coreResetN,
  output logic                           ioPullLow,
  rx_char_sequencer_if.master            rxPort,
  output logic [RETRY_WIDTH-1:0]         retryCount,
  output logic                           fatalError,
  output logic                           overrunError,
  output logic                           cwtTimeout
);

  localparam int                     TW         = CLOCK_PER_BIT_WIDTH + 1;
  localparam logic [TW-1:0]          TIMER_ONE  = 1;
  localparam logic [RETRY_WIDTH:0]   RETRY_ONE  = 1;
  localparam logic [CWT_WIDTH:0]     CWT_ONE    = 1;

  seqState_t              state;
  seqState_t              nextState;
  logic [TW-1:0]          errTimer;
  logic [TW-1:0]          halfBit;
  logic [TW-1:0]          driveLen;
  logic                   timerClear;
  logic                   captureEn;
  logic                   retryBump;
  logic                   fatalSet;
  logic [RETRY_WIDTH:0]   retryInc;
  logic                   endOfRxPrev;
  logic                   endRise;
  logic                   etuTick;
  logic                   cwtArmed;
  logic                   cwtStep;
  logic [CWT_WIDTH-1:0]   cwtCount;
  logic [CWT_WIDTH:0]     cwtNext;
  logic                   unusedStopBit;

  // Parity timing is derived from the ETU length alone, so RxCore's stopBit is not needed.
  assign unusedStopBit = coreStopBit;

  assign halfBit  = TW'(clocksPerBit >> 1);
  assign driveLen = TW'(ERR_HALF_ETUS) * halfBit + TW'(clocksPerBit[0]);
  assign retryInc = {1'b0, retryCount} + RETRY_ONE;
  assign endRise  = coreEndOfRx && !endOfRxPrev;

  etu_ticker #(
    .CLOCK_PER_BIT_WIDTH(CLOCK_PER_BIT_WIDTH)
  ) uEtuTicker (
    .clk          (clk),
    .reset        (reset),
    .restart      (endRise),
    .clocksPerBit (clocksPerBit),
    .tick         (etuTick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      errTimer <= '0;
    end else begin
      state    <= nextState;
      errTimer <= timerClear ? '0 : errTimer + TIMER_ONE;
    end
  end

  always_comb begin
    nextState  = state;
    coreAck    = 1'b0;
    ioPullLow  = 1'b0;
    captureEn  = 1'b0;
    retryBump  = 1'b0;
    fatalSet   = 1'b0;
    timerClear = 1'b1;
    unique case (state)
      IDLE: begin
        if (coreReady && !rxPort.rxValid) begin
          captureEn = 1'b1;
          coreAck   = 1'b1;
        end else if (coreFrameErr) begin
          if (errSignalEn && !fatalError && (retryCount < maxRetries)) begin
            nextState = ERR_WAIT;
          end else begin
            coreAck   = 1'b1;
            retryBump = 1'b1;
            fatalSet  = errSignalEn && (retryInc >= {1'b0, maxRetries});
          end
        end
      end
      ERR_WAIT: begin
        timerClear = 1'b0;
        if (errTimer == halfBit - TIMER_ONE) begin
          nextState  = ERR_DRIVE;
          timerClear = 1'b1;
        end
      end
      ERR_DRIVE: begin
        ioPullLow  = 1'b1;
        timerClear = 1'b0;
        if (errTimer == driveLen - TIMER_ONE) begin
          coreAck    = 1'b1;
          retryBump  = 1'b1;
          nextState  = IDLE;
          timerClear = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
    // Clearing aborts any error signal in progress so the line is released immediately.
    if (clearErrors) begin
      nextState  = IDLE;
      ioPullLow  = 1'b0;
      timerClear = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rxPort.rxData  <= '0;
      rxPort.rxValid <= 1'b0;
      retryCount     <= '0;
      fatalError     <= 1'b0;
      overrunError   <= 1'b0;
      coreResetN     <= 1'b1;
    end else begin
      if (captureEn) begin
        rxPort.rxData  <= coreData;
        rxPort.rxValid <= 1'b1;
      end else if (rxPort.rxValid && rxPort.rxReady) begin
        rxPort.rxValid <= 1'b0;
      end

      if (clearErrors || captureEn) begin
        retryCount <= '0;
      end else if (retryBump && (retryCount != '1)) begin
        retryCount <= retryInc[RETRY_WIDTH-1:0];
      end

      if (clearErrors) begin
        fatalError <= 1'b0;
      end else if (fatalSet) begin
        fatalError <= 1'b1;
      end

      if (clearErrors) begin
        overrunError <= 1'b0;
      end else if (coreOverrun) begin
        overrunError <= 1'b1;
      end

      // RxCore can only leave its overrun state through its own reset.
      coreResetN <= !(clearErrors && overrunError);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      endOfRxPrev <= 1'b0;
    end else begin
      endOfRxPrev <= coreEndOfRx;
    end
  end

  assign cwtStep = cwtArmed && etuTick && (cwtEtus != '0);
  assign cwtNext = {1'b0, cwtCount} + CWT_ONE;

  always_ff @(posedge clk) begin
    if (reset || clearErrors) begin
      cwtArmed   <= 1'b0;
      cwtCount   <= '0;
      cwtTimeout <= 1'b0;
    end else if (endRise) begin
      cwtArmed <= 1'b1;
      cwtCount <= '0;
    end else if (cwtStep) begin
      if (cwtNext >= {1'b0, cwtEtus}) begin
        cwtCount   <= cwtEtus;
        cwtTimeout <= 1'b1;
      end else begin
        cwtCount <= cwtNext[CWT_WIDTH-1:0];
      end
    end
  end

endmodule
